// File: rtl/spgd_dither_seq.sv
// SPGD dither sequencer: per trigger drives U+dU, settles, accumulates J+, then U-dU for J-,
// returns the DAC to nominal U and strobes both sums with j_valid.
module spgd_dither_seq #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADC_WIDTH  = 14,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH  = ADC_WIDTH + CNT_WIDTH
) (
  input  logic                         adc_clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         trig_in,
  input  logic [CNT_WIDTH-1:0]         settle_len,
  input  logic [CNT_WIDTH-1:0]         samp_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0] u_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] du_in,
  input  logic [ADC_WIDTH-1:0]         adc_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] dac_out,
  output logic [1:0]                   dac_sel,
  output logic [ACC_WIDTH-1:0]         jp_out,
  output logic [ACC_WIDTH-1:0]         jm_out,
  output logic                         j_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned VecW = NUM_CH * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle, StArm, StSettleP, StAccP, StSettleM, StAccM, StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 trig_q;
  logic [VecW-1:0]      u_q, u_d, du_q, du_d, dac_q, dac_d;
  logic [CNT_WIDTH-1:0] settle_q, settle_d, samp_q, samp_d, cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, jp_reg_q, jp_reg_d, jp_q, jp_d, jm_q, jm_d;
  logic [1:0]           sel_q, sel_d;
  logic                 jv_q, jv_d, ovr_q, ovr_d;

  logic                 trig_edge;
  logic [VecW-1:0]      dac_plus, dac_minus;
  logic [ACC_WIDTH-1:0] acc_sum;

  // Widen by one bit so the sum cannot wrap before clamping.
  function automatic logic [DATA_WIDTH-1:0] sat_sum(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic                  sub);
    logic [DATA_WIDTH:0] ax, bx, s;
    ax = {a[DATA_WIDTH-1], a};
    bx = {b[DATA_WIDTH-1], b};
    s  = sub ? (ax - bx) : (ax + bx);
    if (s[DATA_WIDTH] == s[DATA_WIDTH-1]) return s[DATA_WIDTH-1:0];
    return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign trig_edge = trig_in & ~trig_q;
  assign busy      = state_q inside {StSettleP, StAccP, StSettleM, StAccM, StDone};
  assign acc_sum   = acc_q + {{(ACC_WIDTH-ADC_WIDTH){adc_in[ADC_WIDTH-1]}}, adc_in};

  // Plus drive is built from live inputs since it is loaded on the trigger cycle itself.
  always_comb begin
    dac_plus  = '0;
    dac_minus = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      dac_plus[k*DATA_WIDTH +: DATA_WIDTH]  = sat_sum(u_in[k*DATA_WIDTH +: DATA_WIDTH],
                                                      du_in[k*DATA_WIDTH +: DATA_WIDTH], 1'b0);
      dac_minus[k*DATA_WIDTH +: DATA_WIDTH] = sat_sum(u_q[k*DATA_WIDTH +: DATA_WIDTH],
                                                      du_q[k*DATA_WIDTH +: DATA_WIDTH], 1'b1);
    end
  end

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    du_d     = du_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    jp_reg_d = jp_reg_q;
    jp_d     = jp_q;
    jm_d     = jm_q;
    dac_d    = dac_q;
    sel_d    = sel_q;
    jv_d     = 1'b0;
    ovr_d    = ovr_q;
    if (!start) begin
      state_d = StIdle;
      dac_d   = u_in;
      sel_d   = 2'b00;
      ovr_d   = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (trig_edge && busy) ovr_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          dac_d   = u_in;
          sel_d   = 2'b00;
          state_d = StArm;
        end
        StArm: begin
          dac_d = u_in;
          sel_d = 2'b00;
          if (trig_edge) begin
            u_d      = u_in;
            du_d     = du_in;
            settle_d = settle_len;
            samp_d   = (samp_len == '0) ? CntOne : samp_len;
            dac_d    = dac_plus;
            sel_d    = 2'b01;
            cnt_d    = '0;
            acc_d    = '0;
            state_d  = (settle_len == '0) ? StAccP : StSettleP;
          end
        end
        StSettleP, StSettleM: begin
          if (cnt_q == settle_q - CntOne) begin
            cnt_d   = '0;
            state_d = (state_q == StSettleP) ? StAccP : StAccM;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StAccP: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == samp_q - CntOne) begin
            jp_reg_d = acc_sum;
            acc_d    = '0;
            cnt_d    = '0;
            dac_d    = dac_minus;
            sel_d    = 2'b10;
            state_d  = (settle_q == '0) ? StAccM : StSettleM;
          end
        end
        StAccM: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == samp_q - CntOne) begin
            // Outputs load on entry to DONE so they are new while j_valid is high.
            jp_d    = jp_reg_q;
            jm_d    = acc_sum;
            jv_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StDone;
          end
        end
        StDone: begin
          dac_d   = u_q;
          sel_d   = 2'b00;
          state_d = StArm;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      trig_q   <= 1'b0;
      u_q      <= '0;
      du_q     <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      jp_reg_q <= '0;
      jp_q     <= '0;
      jm_q     <= '0;
      dac_q    <= '0;
      sel_q    <= 2'b00;
      jv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_in;
      u_q      <= u_d;
      du_q     <= du_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      jp_reg_q <= jp_reg_d;
      jp_q     <= jp_d;
      jm_q     <= jm_d;
      dac_q    <= dac_d;
      sel_q    <= sel_d;
      jv_q     <= jv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dac_out = dac_q;
  assign dac_sel = sel_q;
  assign jp_out  = jp_q;
  assign jm_out  = jm_q;
  assign j_valid = jv_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_spgd_dither_seq.sv
// Directed bench for spgd_dither_seq: reset, full dither sequence, saturation, short phases,
// overrun, start drop and mid-sequence reset.
module tb_spgd_dither_seq;

  localparam int DW = 14;
  localparam int AW = 22;

  logic              adc_clk = 1'b0;
  logic              rst, start, trig_in;
  logic [7:0]        settle_len, samp_len;
  logic [2*DW-1:0]   u_in, du_in, dac_out;
  logic [DW-1:0]     adc_in;
  logic [1:0]        dac_sel;
  logic [AW-1:0]     jp_out, jm_out;
  logic              j_valid, busy, overrun;

  int pass_cnt = 0;
  int total    = 0;

  spgd_dither_seq dut (
    .adc_clk   (adc_clk),
    .rst       (rst),
    .start     (start),
    .trig_in   (trig_in),
    .settle_len(settle_len),
    .samp_len  (samp_len),
    .u_in      (u_in),
    .du_in     (du_in),
    .adc_in    (adc_in),
    .dac_out   (dac_out),
    .dac_sel   (dac_sel),
    .jp_out    (jp_out),
    .jm_out    (jm_out),
    .j_valid   (j_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] pack(input int c0, input int c1);
    logic [DW-1:0] a0, a1;
    a0 = DW'(c0);
    a1 = DW'(c1);
    return {a1, a0};
  endfunction

  function automatic int ch(input int k);
    logic signed [DW-1:0] t;
    t = dac_out[k*DW +: DW];
    return int'(t);
  endfunction

  function automatic int sj(input logic [AW-1:0] x);
    logic signed [AW-1:0] t;
    t = x;
    return int'(t);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; trig_in = 1'b0; adc_in = '0;
    settle_len = 8'd3; samp_len = 8'd10;
    u_in = pack(100, -50); du_in = pack(7, -8);
    tick(); tick();
    total++; if (dac_out !== '0) $display("FAIL rst_dac got %h want 0", dac_out); else pass_cnt++;
    total++; if (dac_sel !== 2'b00) $display("FAIL rst_sel got %b want 00", dac_sel); else pass_cnt++;
    total++;
    if (jp_out !== '0 || jm_out !== '0) $display("FAIL rst_j got %h/%h want 0/0", jp_out, jm_out);
    else pass_cnt++;
    total++;
    if ({j_valid, busy, overrun} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {j_valid, busy, overrun});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total++; if (ch(0) !== 100) $display("FAIL idle_track got %0d want 100", ch(0)); else pass_cnt++;
    start = 1'b1;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL arm_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_main();
    int jv_cnt = 0;
    int jv_at  = -1;
    int e0, e1;
    logic [1:0] es;
    settle_len = 8'd3; samp_len = 8'd10;
    u_in = pack(100, -50); du_in = pack(7, -8);
    trig_in = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 1) trig_in = 1'b0;
      adc_in = (k <= 13) ? DW'(3) : DW'(-3);
      if (j_valid) begin
        jv_cnt++;
        jv_at = k;
        total++;
        if (sj(jp_out) !== 30 || sj(jm_out) !== -30)
          $display("FAIL main_j got %0d/%0d want 30/-30", sj(jp_out), sj(jm_out));
        else pass_cnt++;
      end
      if (k <= 26) begin
        e0 = (k <= 13) ? 107 : 93;
        e1 = (k <= 13) ? -58 : -42;
        es = (k <= 13) ? 2'b01 : 2'b10;
        total++;
        if (ch(0) !== e0 || ch(1) !== e1 || dac_sel !== es || busy !== 1'b1)
          $display("FAIL main_dac k=%0d got %0d,%0d sel %b busy %b want %0d,%0d sel %b busy 1",
                   k, ch(0), ch(1), dac_sel, busy, e0, e1, es);
        else pass_cnt++;
      end
    end
    total++;
    if (jv_cnt !== 1 || jv_at !== 27)
      $display("FAIL main_latency got %0d pulses at %0d want 1 at 27", jv_cnt, jv_at);
    else pass_cnt++;
    total++;
    if (ch(0) !== 100 || ch(1) !== -50 || dac_sel !== 2'b00 || busy !== 1'b0)
      $display("FAIL main_return got %0d,%0d sel %b busy %b want 100,-50 sel 00 busy 0",
               ch(0), ch(1), dac_sel, busy);
    else pass_cnt++;
  endtask

  task automatic test_saturation_short();
    int u0s[2]  = '{8190, -8190};
    int eps[2]  = '{8191, -8185};
    int ems[2]  = '{8185, -8192};
    settle_len = 8'd0; samp_len = 8'd0;
    for (int c = 0; c < 2; c++) begin
      u_in = pack(u0s[c], -50); du_in = pack(5, -8);
      trig_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k == 1) trig_in = 1'b0;
        adc_in = (k == 1) ? DW'(123) : DW'(-77);
        if (k == 1) begin
          total++;
          if (ch(0) !== eps[c] || ch(1) !== -58 || dac_sel !== 2'b01)
            $display("FAIL sat_plus c=%0d got %0d,%0d sel %b want %0d,-58 sel 01",
                     c, ch(0), ch(1), dac_sel, eps[c]);
          else pass_cnt++;
        end
        if (k == 2) begin
          total++;
          if (ch(0) !== ems[c] || ch(1) !== -42 || dac_sel !== 2'b10 || j_valid !== 1'b0)
            $display("FAIL sat_minus c=%0d got %0d,%0d sel %b jv %b want %0d,-42 sel 10 jv 0",
                     c, ch(0), ch(1), dac_sel, j_valid, ems[c]);
          else pass_cnt++;
        end
        if (k == 3) begin
          total++;
          if (j_valid !== 1'b1 || sj(jp_out) !== 123 || sj(jm_out) !== -77)
            $display("FAIL short_j c=%0d got jv %b %0d/%0d want jv 1 123/-77",
                     c, j_valid, sj(jp_out), sj(jm_out));
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_overrun();
    int jv_cnt = 0;
    settle_len = 8'd3; samp_len = 8'd10;
    u_in = pack(100, -50); du_in = pack(7, -8);
    trig_in = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 2 || k == 8) trig_in = 1'b0;
      if (k == 5) trig_in = 1'b1;
      adc_in = (k <= 13) ? DW'(3) : DW'(-3);
      if (j_valid) jv_cnt++;
      if (k == 6) begin
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun);
        else pass_cnt++;
      end
      if (k == 27) begin
        total++;
        if (j_valid !== 1'b1 || sj(jp_out) !== 30 || sj(jm_out) !== -30)
          $display("FAIL ovr_first got jv %b %0d/%0d want jv 1 30/-30",
                   j_valid, sj(jp_out), sj(jm_out));
        else pass_cnt++;
      end
    end
    total++;
    if (overrun !== 1'b1 || busy !== 1'b0 || jv_cnt !== 1)
      $display("FAIL ovr_sticky got ovr %b busy %b pulses %0d want 1 0 1", overrun, busy, jv_cnt);
    else pass_cnt++;
  endtask

  task automatic test_start_drop();
    int jv_cnt = 0;
    u_in = pack(100, -50); du_in = pack(7, -8);
    adc_in = DW'(5);
    trig_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) trig_in = 1'b0;
      if (k == 15) start = 1'b0;
      if (k == 18) start = 1'b1;
      if (j_valid) jv_cnt++;
      if (k == 16) begin
        total++;
        if (busy !== 1'b0 || dac_sel !== 2'b00 || ch(0) !== 100 || ch(1) !== -50 ||
            overrun !== 1'b0)
          $display("FAIL drop_idle got busy %b sel %b dac %0d,%0d ovr %b want 0 00 100,-50 0",
                   busy, dac_sel, ch(0), ch(1), overrun);
        else pass_cnt++;
      end
    end
    total++;
    if (jv_cnt !== 0 || sj(jp_out) !== 30 || sj(jm_out) !== -30)
      $display("FAIL drop_hold got pulses %0d j %0d/%0d want 0 30/-30",
               jv_cnt, sj(jp_out), sj(jm_out));
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    adc_in = DW'(2);
    trig_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) trig_in = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 4) begin
        total++; if (busy !== 1'b1) $display("FAIL rstmid_busy got %b want 1", busy);
        else pass_cnt++;
      end
    end
    total++;
    if (dac_out !== '0 || dac_sel !== 2'b00 || busy !== 1'b0 || jp_out !== '0 || jm_out !== '0)
      $display("FAIL rstmid got dac %h sel %b busy %b j %h/%h want all 0",
               dac_out, dac_sel, busy, jp_out, jm_out);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_main();
    test_saturation_short();
    test_overrun();
    test_start_drop();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spgd_dither_seq.md
Name: spgd_dither_seq

Overview:
- Parametrised successor to the single-pair FSM, counter and DAC mux sequencing; runs one complete SPGD dither measurement per trigger.
- Per trigger edge: drives U+dU to all channels, waits a settle time, and accumulates ADC samples into J+. Then drives U−dU, settles, and accumulates J−.
- Returns the DAC to nominal U and strobes J+/J− to the update logic.
- Channel count, widths and runtime settle/sample lengths are generic; adds saturation, abort and overrun detection.

Parameters:
- DATA_WIDTH, 14, signed DAC word width per channel
- NUM_CH, 2, number of DAC channels
- ADC_WIDTH, 14, signed ADC sample width
- CNT_WIDTH, 8, width of settle/sample length inputs and internal counters
- ACC_WIDTH, ADC_WIDTH+CNT_WIDTH, signed accumulator and J output width

Ports:
- adc_clk, in, 1, sole clock; rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, run enable; low forces IDLE
- trig_in, in, 1, asynchronous-rate trigger; rising edge starts a measurement
- settle_len, in, CNT_WIDTH, settle cycles per phase; sampled at trigger edge
- samp_len, in, CNT_WIDTH, accumulate cycles per phase; sampled at trigger edge
- u_in, in, NUM_CH*DATA_WIDTH, nominal signed control vector; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- du_in, in, NUM_CH*DATA_WIDTH, signed perturbation vector; same packing
- adc_in, in, ADC_WIDTH, signed ADC sample
- dac_out, out, NUM_CH*DATA_WIDTH, registered DAC drive
- dac_sel, out, 2, phase: 00 nominal, 01 plus, 10 minus
- jp_out, out, ACC_WIDTH, signed J+ sum
- jm_out, out, ACC_WIDTH, signed J− sum
- j_valid, out, 1, one-cycle strobe; jp_out/jm_out new
- busy, out, 1, high from SETTLE_P through DONE
- overrun, out, 1, sticky; trigger edge seen while busy

Behaviour:
- Reset: state=IDLE, dac_out=0, dac_sel=00, jp_out=jm_out=0, j_valid=0, busy=0, overrun=0, trig_d=0, accumulators and counters=0.
- Edge detect: trig_d registers trig_in every cycle. edge = trig_in & ~trig_d. Synchroniser not included; trig_in is pre-synchronised upstream.
- IDLE: dac_out=u_in (tracks live), dac_sel=00. start=1 → ARM next cycle.
- ARM: dac_out=u_in live. On edge:
  - latch u_in, du_in, settle_len, samp_len; samp_len=0 latches as 1
  - dac_out←sat(u+du) per channel, dac_sel←01, counter←0, acc←0 → SETTLE_P
- SETTLE_P: count settle_len cycles, then → ACC_P. settle_len=0 gives zero SETTLE_P cycles; go directly to ACC_P.
- ACC_P: acc += sign-extended adc_in each cycle for samp_len cycles. On the last cycle:
  - jp_reg←final sum, acc←0
  - dac_out←sat(u−du), dac_sel←10 → SETTLE_M
- SETTLE_M / ACC_M: mirror the plus phase; the final sum goes to jm_reg → DONE.
- DONE (one cycle):
  - jp_out←jp_reg, jm_out←jm_reg, j_valid=1
  - dac_out←latched u, dac_sel←00 → ARM
- Latency: first edge cycle to j_valid = 2*(settle_len+samp_len)+1 cycles.
- Arithmetic:
  - sat() saturates the DATA_WIDTH+1 bit sum to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]
  - accumulator wraps two's complement; no overflow possible when ACC_WIDTH ≥ ADC_WIDTH+CNT_WIDTH
- Edge while busy: ignored for sequencing; overrun←1 (sticky until rst or start=0).
- Edge in the same cycle as DONE: counts as busy → overrun, no new measurement.
- start=0 in any state:
  - next cycle state=IDLE, dac_out=u_in, dac_sel=00, busy=0, overrun←0
  - partial sums discarded; no j_valid
  - jp_out/jm_out hold their last values
- rst mid-sequence: full reset values next cycle.
- Input changes mid-sequence have no effect (latched copies used).

Test Plan:
- NUM_CH=2; u0=100, du0=7, u1=−50, du1=−8; settle=3, samp=10 → dac ch0 107 for 13 cycles then 93; ch1 −58 then −42; dac_sel 01→10→00; j_valid 27 cycles after edge.
- adc_in=+3 during plus phase, −3 during minus → jp_out=30, jm_out=−30, single j_valid pulse.
- u0=8190, du0=5 → ch0 plus=8191 (saturated), minus=8185; u0=−8190, du0=5 → minus=−8192.
- settle=0, samp=0 → samp treated as 1; j_valid 3 cycles after edge; jp_out equals a single adc_in sample.
- Second trig edge during ACC_P → overrun=1 stays high; first measurement completes normally; no second measurement starts.
- start dropped during SETTLE_M → IDLE next cycle, dac_out=u_in, no j_valid, jp_out/jm_out keep previous values, overrun cleared.
